// File: rtl/dpram_pkg.sv
// dpram_pkg: default geometry and word/address types for dual_port_ram (16 x 8)
package dpram_pkg;
  localparam int DPRAM_DATA_WIDTH = 8;
  localparam int DPRAM_ADDR_WIDTH = 4;
  localparam int DPRAM_DEPTH = 16;
  typedef logic [DPRAM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DPRAM_DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/dpram_storage.sv
// dpram_storage: memory array with sync clear (rst active-low) and write port (wr_en/w_addr/w_data), async read word rd_word at rd_addr
module dpram_storage
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH,
  parameter int DEPTH = DPRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_word
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (!rst)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr_en)
      mem[w_addr] <= w_data;
  assign rd_word = mem[rd_addr];
endmodule

// File: rtl/dual_port_ram.sv
// dual_port_ram: 1W/1R sync RAM; ports clk, rst (sync active-low), wr_en/w_addr/w_data, rd_en/rd_addr, registered rd_data; DPRAM_WR_BYPASS_EN selects write-first on collision
module dual_port_ram
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH,
  parameter int DEPTH = DPRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  if (DEPTH != 2 ** ADDR_WIDTH) begin : g_depth_chk
    $error("dual_port_ram: DEPTH must equal 2**ADDR_WIDTH");
  end
  logic [DATA_WIDTH-1:0] rd_word, rd_next;
  dpram_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH)
  ) u_storage (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .rd_addr(rd_addr),
    .rd_word(rd_word)
  );
`ifdef DPRAM_WR_BYPASS_EN
  assign rd_next = (wr_en && w_addr == rd_addr) ? w_data : rd_word;
`else
  assign rd_next = rd_word;
`endif
  always_ff @(posedge clk)
    if (!rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= rd_next;
endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed self-checking bench for dual_port_ram
module tb_dual_port_ram;
  import dpram_pkg::*;
  logic clk = 0, rst = 0, wr_en = 0, rd_en = 0;
  addr_t w_addr = '0, rd_addr = '0;
  data_t w_data = '0;
  data_t rd_data;
  data_t model [16];
  int checks = 0, errors = 0;
  dual_port_ram dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input data_t obs, input data_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input addr_t a, input data_t d);
    wr_en = 1; w_addr = a; w_data = d;
    tick();
    wr_en = 0;
    model[a] = d;
  endtask
  task automatic rd(input string tag, input addr_t a, input data_t exp);
    rd_en = 1; rd_addr = a;
    tick();
    rd_en = 0;
    chk(tag, rd_data, exp);
  endtask
  initial begin
    addr_t a;
    data_t d;
    for (int i = 0; i < 16; i++) model[i] = '0;
    tick();
    tick();
    chk("reset_rd_data", rd_data, 8'h00);
    rst = 1;
    for (int i = 0; i < 16; i++) rd("reset_mem", addr_t'(i), 8'h00);
    wr(4'd3, 8'hA5);
    rd_en = 1; rd_addr = 4'd3;
    #1;
    chk("latency_pre_edge", rd_data, 8'h00);
    tick();
    rd_en = 0;
    chk("write_read_a5", rd_data, 8'hA5);
    rd_addr = 4'd7;
    tick();
    chk("hold_1", rd_data, 8'hA5);
    tick();
    chk("hold_2", rd_data, 8'hA5);
    w_addr = 4'd4; w_data = 8'hEE;
    tick();
    rd("wr_en_low_no_write", 4'd4, 8'h00);
    wr(4'd5, 8'h11);
    wr_en = 1; w_addr = 4'd5; w_data = 8'h22; rd_en = 1; rd_addr = 4'd5;
    tick();
    wr_en = 0; rd_en = 0;
    model[5] = 8'h22;
`ifdef DPRAM_WR_BYPASS_EN
    chk("collision", rd_data, 8'h22);
`else
    chk("collision", rd_data, 8'h11);
`endif
    rd("collision_after", 4'd5, 8'h22);
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      wr(a, d);
      if (i % 3 == 0) wr(a, 8'($urandom_range(0, 255)));
      rd("random_readback", a, model[a]);
    end
    for (int i = 0; i < 16; i++) rd("random_sweep", addr_t'(i), model[i]);
    wr(4'd9, 8'hFF);
    rst = 0; wr_en = 1; w_addr = 4'd2; w_data = 8'h77; rd_en = 1; rd_addr = 4'd9;
    tick();
    rst = 1; wr_en = 0; rd_en = 0;
    chk("midop_reset_rd_data", rd_data, 8'h00);
    rd("midop_reset_addr9", 4'd9, 8'h00);
    rd("midop_reset_addr2", 4'd2, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
